wb_stage: RTL

//  Writeback stage of the MIPS core, directly upstream of reg_file.
//  - Accepts retiring instructions from MEM; selects ALU, load or link data.
//  - Aligns and extends load data.
//  - Waits for multi-cycle data memory and stalls MEM while waiting.
//  - Drives reg_file i_data / write_addr / we.

---
 rtl/wb_stage_pkg.sv | 13 +
 rtl/wb_stage_load_align.sv | 20 ++
 rtl/wb_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: writeback-select and load-type codes shared with the MEM stage,
// plus the writeback FSM state type.
package wb_stage_pkg;
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_LINK = 2'd2;
   localparam logic [2:0] LT_LW   = 3'd0;
   localparam logic [2:0] LT_LH   = 3'd1;
   localparam logic [2:0] LT_LHU  = 3'd2;
   localparam logic [2:0] LT_LB   = 3'd3;
   localparam logic [2:0] LT_LBU  = 3'd4;
   typedef enum logic {IDLE, WAIT_MEM} state_t;
endpackage

// File: rtl/wb_stage_load_align.sv
// wb_stage_load_align: little-endian extraction and sign/zero extension of load data.
module wb_stage_load_align
   import wb_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  load_type,
   input  logic [1:0]  byte_off,
   output logic [31:0] data
);
   logic [15:0] half;
   logic [7:0]  byte_v;
   always_comb begin
      half   = byte_off[1] ? rdata[31:16] : rdata[15:0];
      byte_v = rdata[{byte_off, 3'b000} +: 8];
      data   = load_type == LT_LH  ? {{16{half[15]}}, half} :
               load_type == LT_LHU ? {16'h0000, half} :
               load_type == LT_LB  ? {{24{byte_v[7]}}, byte_v} :
               load_type == LT_LBU ? {24'h000000, byte_v} : rdata;
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage; selects ALU/load/link data, waits for slow loads
// and drives registered write port signals into reg_file.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [1:0]            in_wb_sel,
   input  logic [DATA_WIDTH-1:0] in_alu_result,
   input  logic [DATA_WIDTH-1:0] in_link_pc,
   input  logic [2:0]            in_load_type,
   input  logic [1:0]            in_byte_off,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  flush,
   output logic                  wb_we,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  busy
);
   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] p_rd, c_rd;
   logic                  p_rw, c_rw;
   logic [2:0]            p_lt, a_lt;
   logic [1:0]            p_off, a_off;
   logic [DATA_WIDTH-1:0] aligned, c_data;
   logic                  is_load, accept, defer, commit;

   wb_stage_load_align u_align (
      .rdata(mem_rdata),
      .load_type(a_lt),
      .byte_off(a_off),
      .data(aligned)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   // While waiting, the aligner and commit fields come from the latched load.
   always_comb begin
      in_ready = state == IDLE;
      busy     = state == WAIT_MEM;
      is_load  = in_wb_sel == WB_MEM;
      accept   = in_valid & in_ready & ~flush;
      defer    = accept & is_load & ~mem_rvalid;
      commit   = busy ? mem_rvalid & ~flush : accept & ~defer;
      a_lt     = busy ? p_lt : in_load_type;
      a_off    = busy ? p_off : in_byte_off;
      c_rd     = busy ? p_rd : in_rd;
      c_rw     = busy ? p_rw : in_reg_write;
      c_data   = (busy | is_load) ? aligned : in_wb_sel == WB_LINK ? in_link_pc : in_alu_result;
      state_nx = defer ? WAIT_MEM : (commit | flush) ? IDLE : state;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wb_we   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         p_rd    <= '0;
         p_rw    <= 1'b0;
         p_lt    <= LT_LW;
         p_off   <= 2'd0;
      end else begin
         wb_we <= commit & c_rw & (c_rd != '0);
         if (commit) begin
            wb_addr <= c_rd;
            wb_data <= c_data;
         end
         if (defer) begin
            p_rd  <= in_rd;
            p_rw  <= in_reg_write;
            p_lt  <= in_load_type;
            p_off <= in_byte_off;
         end
      end
endmodule
